data_cache: RTL

- Responder side of the CPU data-memory interface.
- Consumes the pipeline's stage-4 memory request (address, store data, read/write enables) and returns load data plus a busy-wait stall.
- Direct-mapped, write-back, write-allocate cache with 16-byte blocks.
- Sits between the cpu and the main data memory, and drives a block-wide request/busywait handshake toward that memory.

---
 rtl/data_cache_pkg.sv | 33 +++
 rtl/data_cache_align.sv | 68 ++++++
 rtl/data_cache.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/data_cache_pkg.sv
// Shared definitions for the data cache: request encodings, FSM states and
// block geometry.
package data_cache_pkg;

  // Block geometry: 16-byte blocks, so ADDR[3:0] is the byte offset.
  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_BITS  = 8 * BLOCK_BYTES;

  // Bit positions of the request strobes inside READ_EN / WRITE_EN.
  localparam int READ_REQ_BIT  = 3;
  localparam int WRITE_REQ_BIT = 2;

  // Load funct3 codes carried in READ_EN[2:0].
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store size codes carried in WRITE_EN[1:0].
  localparam logic [1:0] SZ_SB = 2'b00;
  localparam logic [1:0] SZ_SH = 2'b01;
  localparam logic [1:0] SZ_SW = 2'b10;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    FILL      = 2'd3
  } state_t;

endpackage

// File: rtl/data_cache_align.sv
// Byte-lane steering between the CPU and one 128-bit cache line:
// load extract plus sign/zero extension, and store lane mask plus
// data replication so any lane can be picked out of the replicated word.
module data_cache_align
  import data_cache_pkg::*;
(
  input  logic [BLOCK_BITS-1:0]  line,
  input  logic [3:0]             offset,
  input  logic [2:0]             load_funct3,
  input  logic [1:0]             store_size,
  input  logic [31:0]            store_data,
  output logic [31:0]            load_data,
  output logic [BLOCK_BYTES-1:0] store_mask,
  output logic [BLOCK_BITS-1:0]  store_line
);

  logic [31:0] word;
  logic [15:0] half;
  logic [7:0]  byte_val;

  // Pick the addressed word, then the halfword/byte inside it; halfword
  // selection ignores offset[0], word selection ignores offset[1:0].
  always_comb begin
    word     = line[{offset[3:2], 5'b0} +: 32];
    half     = word[{offset[1], 4'b0} +: 16];
    byte_val = word[{offset[1:0], 3'b0} +: 8];
  end

  // Extend the selected field; unlisted funct3 codes return the whole word.
  // NOTE: every output of a combinational block gets a default on entry,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    load_data = word;
    case (load_funct3)
      F3_LB:   load_data = {{24{byte_val[7]}}, byte_val};
      F3_LH:   load_data = {{16{half[15]}}, half};
      F3_LBU:  load_data = {24'b0, byte_val};
      F3_LHU:  load_data = {16'b0, half};
      default: load_data = word;
    endcase
  end

  // Build the byte-enable mask and a line image with the store data
  // replicated into every lane of its size; an unknown size writes nothing.
  always_comb begin
    store_mask = '0;
    store_line = '0;
    case (store_size)
      SZ_SB: begin
        store_mask = 16'h0001 << offset;
        store_line = {16{store_data[7:0]}};
      end
      SZ_SH: begin
        store_mask = 16'h0003 << {offset[3:1], 1'b0};
        store_line = {8{store_data[15:0]}};
      end
      SZ_SW: begin
        store_mask = 16'h000F << {offset[3:2], 2'b00};
        store_line = {4{store_data}};
      end
      default: begin
        store_mask = '0;
        store_line = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte blocks.
// Loads hit with zero latency; misses stall the CPU through BUSY_WAIT while
// the controller writes back a dirty victim and fetches the new block.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int LINES      = 8,
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 28 - INDEX_BITS
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [3:0]            READ_EN,
  input  logic [2:0]            WRITE_EN,
  input  logic [31:0]           ADDR,
  input  logic [31:0]           WRITE_DATA,
  output logic [31:0]           READ_DATA,
  output logic                  BUSY_WAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [27:0]           MEM_ADDR,
  output logic [BLOCK_BITS-1:0] MEM_WRITE_DATA,
  input  logic [BLOCK_BITS-1:0] MEM_READ_DATA,
  input  logic                  MEM_BUSY_WAIT
);

  // Line storage: status bits are reset, tag and data arrays are not.
  logic [LINES-1:0]      valid;
  logic [LINES-1:0]      dirty;
  logic [TAG_BITS-1:0]   tag_arr  [LINES];
  logic [BLOCK_BITS-1:0] data_arr [LINES];

  state_t state;

  // Address decomposition.
  logic [3:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   addr_tag;

  logic load_req;
  logic store_req;
  logic req;
  logic hit;

  // Aligner results and line write controls.
  logic [31:0]            align_load;
  logic [BLOCK_BYTES-1:0] store_mask;
  logic [BLOCK_BITS-1:0]  store_line;
  logic [BLOCK_BYTES-1:0] line_we_mask;
  logic [BLOCK_BITS-1:0]  line_wdata;
  logic                   tag_we;

  assign offset    = ADDR[3:0];
  assign index     = ADDR[3+INDEX_BITS:4];
  assign addr_tag  = ADDR[31:4+INDEX_BITS];
  assign load_req  = READ_EN[READ_REQ_BIT];
  assign store_req = WRITE_EN[WRITE_REQ_BIT];
  assign req       = load_req | store_req;
  assign hit       = valid[index] && (tag_arr[index] == addr_tag);

  data_cache_align u_align (
    .line        (data_arr[index]),
    .offset      (offset),
    .load_funct3 (READ_EN[2:0]),
    .store_size  (WRITE_EN[1:0]),
    .store_data  (WRITE_DATA),
    .load_data   (align_load),
    .store_mask  (store_mask),
    .store_line  (store_line)
  );

  // CPU-facing outputs: stall on a miss in IDLE and throughout a refill;
  // load data is driven only on a hit and reflects the pre-store contents.
  always_comb begin
    BUSY_WAIT = 1'b1;
    if (state == IDLE) begin
      BUSY_WAIT = req & ~hit;
    end
    READ_DATA = (load_req && hit) ? align_load : 32'b0;
  end

  // Select what gets written into the indexed line this cycle: store-hit
  // bytes in IDLE, or the whole fetched block when the memory read completes.
  always_comb begin
    line_we_mask = '0;
    line_wdata   = store_line;
    tag_we       = 1'b0;
    if (!RESET) begin
      case (state)
        IDLE: begin
          if (store_req && hit) begin
            line_we_mask = store_mask;
          end
        end
        ALLOCATE: begin
          if (!MEM_BUSY_WAIT) begin
            line_we_mask = '1;
            line_wdata   = MEM_READ_DATA;
            tag_we       = 1'b1;
          end
        end
        default: begin
          line_we_mask = '0;
        end
      endcase
    end
  end

  // Tag and data arrays: byte-masked writes into the indexed line.
  // NOTE: the arrays carry no reset; a line is only ever read through a
  // valid bit, and the valid bits are what reset clears.
  always_ff @(posedge CLK) begin
    if (tag_we) begin
      tag_arr[index] <= addr_tag;
    end
    for (int b = 0; b < BLOCK_BYTES; b++) begin
      if (line_we_mask[b]) begin
        data_arr[index][8*b +: 8] <= line_wdata[8*b +: 8];
      end
    end
  end

  // Miss controller: state, status bits and the registered memory handshake.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= IDLE;
      valid          <= '0;
      dirty          <= '0;
      MEM_READ       <= 1'b0;
      MEM_WRITE      <= 1'b0;
      MEM_ADDR       <= '0;
      MEM_WRITE_DATA <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            if (valid[index] && dirty[index]) begin
              state          <= WRITEBACK;
              MEM_WRITE      <= 1'b1;
              MEM_ADDR       <= {tag_arr[index], index};
              MEM_WRITE_DATA <= data_arr[index];
            end else begin
              state    <= ALLOCATE;
              MEM_READ <= 1'b1;
              MEM_ADDR <= ADDR[31:4];
            end
          end else if (store_req && hit) begin
            dirty[index] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSY_WAIT) begin
            state     <= ALLOCATE;
            MEM_WRITE <= 1'b0;
            MEM_READ  <= 1'b1;
            MEM_ADDR  <= ADDR[31:4];
          end
        end
        ALLOCATE: begin
          if (!MEM_BUSY_WAIT) begin
            state        <= FILL;
            MEM_READ     <= 1'b0;
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
          end
        end
        FILL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
